// File: rtl/divclk_period_monitor_if.sv
// Interface bundling the measured-signal inputs and the monitor's status outputs.
//   master : drives en/din, observes results (testbench or upstream BIST controller)
//   slave  : the monitor itself
// Signals:
//   en          measurement enable
//   din         divided toggle signal under test
//   half_period last measured half-period (CNT_W bits)
//   meas_valid  one-cycle pulse when half_period updates
//   locked      run of in-tolerance measurements reached
//   err         sticky loss-of-lock indicator
//   ovf         sticky counter-saturation indicator
interface divclk_period_monitor_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             din;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic             ovf;

    modport master (output en, din,
                    input  half_period, meas_valid, locked, err, ovf);
    modport slave  (input  en, din,
                    output half_period, meas_valid, locked, err, ovf);
endinterface

// File: rtl/divclk_period_monitor.sv
// divclk_period_monitor
// Measures every half-period (both edges) of a slow toggle signal in i_clk
// cycles and declares lock after LOCK_CNT consecutive measurements within
// EXP_HALF +/- TOL. Loss of lock (mismatch or saturation) sets a sticky err;
// counter saturation sets a sticky ovf. Both clear only on reset.
// Ports:
//   i_clk  sole clock, rising edge
//   reset  synchronous, active-high, clears all state
//   bus    divclk_period_monitor_if.slave (en, din in; half_period,
//          meas_valid, locked, err, ovf out; all outputs registered)
// Build option:
//   DIVMON_SYNC_EN  when defined, din passes a 2-flop synchronizer before edge
//                   detection (all din-relative latencies grow by 2 cycles).
module divclk_period_monitor #(
    parameter int CNT_W    = 16,
    parameter int EXP_HALF = 4,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4
) (
    input  logic                    i_clk,
    input  logic                    reset,
    divclk_period_monitor_if.slave  bus
);
    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int LO   = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
    localparam int HI   = EXP_HALF + TOL;
    // One extra bit so the tolerance window never wraps around.
    localparam logic [CNT_W:0]  LO_V   = (CNT_W+1)'(LO);
    localparam logic [CNT_W:0]  HI_V   = (CNT_W+1)'(HI);
    localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, hp_q, hp_n;
    logic [MC_W-1:0]  match_cnt, mc_n, mc_inc;
    logic             mv_q, mv_n, lk_q, lk_n, err_q, err_n, ovf_q, ovf_n;
    logic             din_s, d_q, tgl, cnt_sat, match;

`ifdef DIVMON_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge i_clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], bus.din};
    end
    assign din_s = sync_q[1];
`else
    assign din_s = bus.din;
`endif

    assign tgl     = din_s ^ d_q;
    assign cnt_sat = (cnt == {CNT_W{1'b1}});
    assign match   = ({1'b0, cnt} >= LO_V) && ({1'b0, cnt} <= HI_V);
    assign mc_inc  = match_cnt + MC_W'(1);

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            match_cnt <= '0;
            d_q       <= 1'b0;
            hp_q      <= '0;
            mv_q      <= 1'b0;
            lk_q      <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            match_cnt <= mc_n;
            d_q       <= din_s;     // tracks din in every state, so re-enable sees no stale edge
            hp_q      <= hp_n;
            mv_q      <= mv_n;
            lk_q      <= lk_n;
            err_q     <= err_n;
            ovf_q     <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mc_n    = match_cnt;
        hp_n    = hp_q;
        mv_n    = 1'b0;
        lk_n    = lk_q;
        err_n   = err_q;
        ovf_n   = ovf_q;
        if (!bus.en) begin
            state_n = IDLE;
            cnt_n   = '0;
            mc_n    = '0;
            lk_n    = 1'b0;
        end else begin
            // Edge restarts at 1 so a half-period of H cycles reads back as H.
            cnt_n = tgl ? CNT_W'(1) : (cnt_sat ? cnt : cnt + CNT_W'(1));
            case (state)
                IDLE: begin
                    state_n = ARM;
                    cnt_n   = '0;
                    mc_n    = '0;
                end
                ARM: begin
                    // First edge only establishes phase; nothing to measure yet.
                    if (tgl) state_n = MEASURE;
                end
                MEASURE, LOCKED: begin
                    if (tgl) begin
                        hp_n = cnt;
                        mv_n = 1'b1;
                        if (match) begin
                            if (state == MEASURE) begin
                                mc_n = mc_inc;
                                if (mc_inc == LOCK_V) begin
                                    state_n = LOCKED;
                                    lk_n    = 1'b1;
                                end
                            end
                        end else begin
                            mc_n = '0;
                            if (state == LOCKED) begin
                                err_n   = 1'b1;
                                lk_n    = 1'b0;
                                state_n = MEASURE;
                            end
                        end
                    end else if (cnt_sat) begin
                        // Edge takes priority over saturation (handled above).
                        ovf_n   = 1'b1;
                        lk_n    = 1'b0;
                        mc_n    = '0;
                        state_n = ARM;
                        if (state == LOCKED) err_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.half_period = hp_q;
    assign bus.meas_valid  = mv_q;
    assign bus.locked      = lk_q;
    assign bus.err         = err_q;
    assign bus.ovf         = ovf_q;
endmodule
